// File: rtl/rsc_encoder_if.sv
// Stream interface of the LTE RSC encoder: block-length strobe, serial info-bit input,
// and the mapped systematic/parity sample stream toward the SISO decoder.
interface rsc_encoder_if;
   logic [15:0] blklen;
   logic        valid_blklen;
   logic        in_bit;
   logic        valid_in;
   logic        ready;
   logic [15:0] sys;
   logic [15:0] par;
   logic        valid_out;
   logic        tail_out;
   logic        last_out;
   logic        len_err;

   modport master (
      output blklen, valid_blklen, in_bit, valid_in,
      input  ready, sys, par, valid_out, tail_out, last_out, len_err
   );

   modport slave (
      input  blklen, valid_blklen, in_bit, valid_in,
      output ready, sys, par, valid_out, tail_out, last_out, len_err
   );
endinterface

// File: rtl/rsc_encoder.sv
// LTE constituent RSC encoder (feedback 1+D^2+D^3, parity 1+D+D^3) with 3-step trellis
// termination, emitting BPSK-mapped 16-bit systematic/parity samples one cycle after each step.
module rsc_encoder #(
   parameter logic signed [15:0] AMP     = 16'sd64,
   parameter int                 MIN_LEN = 40,
   parameter int                 MAX_LEN = 6144
) (
   input logic         clk,
   input logic         rst,
   rsc_encoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ENCODE, TAIL} state_t;

   localparam logic [15:0] MIN_L = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L = 16'(MAX_LEN);

   state_t      state;
   logic [12:0] count;
   logic [12:0] k_len;
   logic [1:0]  tail_cnt;
   logic        s1, s2, s3;
   logic        ready_q, valid_q, tail_q, last_q, len_err_q;
   logic [15:0] sys_q, par_q;

   logic u, a, z, len_ok;

   function automatic logic [15:0] map_bit(input logic b);
      return b ? -AMP : AMP;
   endfunction

   // In TAIL the input is chosen as s2^s3 so the feedback bit a is forced to zero,
   // which flushes the trellis back to state 000 in three steps.
   always_comb begin
      u      = (state == TAIL) ? (s2 ^ s3) : bus.in_bit;
      a      = u ^ s2 ^ s3;
      z      = a ^ s1 ^ s3;
      len_ok = (bus.blklen >= MIN_L) && (bus.blklen <= MAX_L);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         k_len     <= '0;
         tail_cnt  <= '0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         tail_q    <= 1'b0;
         last_q    <= 1'b0;
         len_err_q <= 1'b0;
         sys_q     <= '0;
         par_q     <= '0;
      end else begin
         valid_q   <= 1'b0;
         tail_q    <= 1'b0;
         last_q    <= 1'b0;
         len_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.valid_blklen) begin
                  if (len_ok) begin
                     state   <= ENCODE;
                     k_len   <= bus.blklen[12:0];
                     count   <= '0;
                     s1      <= 1'b0;
                     s2      <= 1'b0;
                     s3      <= 1'b0;
                     ready_q <= 1'b1;
                  end else begin
                     len_err_q <= 1'b1;
                  end
               end
            end
            ENCODE: begin
               if (bus.valid_in && ready_q) begin
                  s1      <= a;
                  s2      <= s1;
                  s3      <= s2;
                  count   <= count + 13'd1;
                  sys_q   <= map_bit(u);
                  par_q   <= map_bit(z);
                  valid_q <= 1'b1;
                  // Dropping ready on the K-th accept guarantees no extra bit slips in.
                  if (count == k_len - 13'd1) begin
                     ready_q  <= 1'b0;
                     tail_cnt <= '0;
                     state    <= TAIL;
                  end
               end
            end
            TAIL: begin
               s1       <= a;
               s2       <= s1;
               s3       <= s2;
               sys_q    <= map_bit(u);
               par_q    <= map_bit(z);
               valid_q  <= 1'b1;
               tail_q   <= 1'b1;
               tail_cnt <= tail_cnt + 2'd1;
               if (tail_cnt == 2'd2) begin
                  last_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready     = ready_q;
   assign bus.sys       = sys_q;
   assign bus.par       = par_q;
   assign bus.valid_out = valid_q;
   assign bus.tail_out  = tail_q;
   assign bus.last_out  = last_q;
   assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_rsc_encoder.sv
// Randomized bench for rsc_encoder: each block's output stream is compared with a
// generator-polynomial recursion model of the LTE constituent code including termination.
module tb_rsc_encoder;

   localparam logic [15:0] AMP = 16'd64;

   typedef struct {
      logic [15:0] sys;
      logic [15:0] par;
      logic        tl;
      logic        ls;
      int          cyc;
   } obs_t;

   logic clk;
   logic rst;
   rsc_encoder_if bus ();

   rsc_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   errors;
   int   checks;
   int   cyc;
   int   len_err_cnt;
   logic mon_acc;
   bit   blk_bits[$];
   obs_t obs_q[$];
   obs_t exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] mapBit(input bit b);
      return b ? (16'd0 - AMP) : AMP;
   endfunction

   // Code model: a[n] = u[n]^a[n-2]^a[n-3], z[n] = a[n]^a[n-1]^a[n-3];
   // termination picks u so that a[n] = 0 for three steps.
   task automatic buildExpected(input int k);
      int hist[$];
      int am1, am2, am3, av, x, zv, n_h;
      exp_q.delete();
      hist = '{0, 0, 0};
      for (int n = 0; n < k + 3; n++) begin
         n_h = hist.size();
         am1 = hist[n_h-1];
         am2 = hist[n_h-2];
         am3 = hist[n_h-3];
         if (n < k) begin
            x  = int'(blk_bits[n]);
            av = x ^ am2 ^ am3;
         end else begin
            av = 0;
            x  = am2 ^ am3;
         end
         zv = av ^ am1 ^ am3;
         hist.push_back(av);
         exp_q.push_back('{mapBit(x[0]), mapBit(zv[0]), n >= k, n == k + 2, 0});
      end
   endtask

   // Monitor: sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      mon_acc = bus.valid_in && bus.ready && !rst;
      #1;
      cyc++;
      if (mon_acc) checkOutput("latency", bus.valid_out, 1);
      if (bus.valid_out === 1'b1)
         obs_q.push_back('{bus.sys, bus.par, bus.tail_out, bus.last_out, cyc});
      if (bus.len_err === 1'b1) len_err_cnt++;
   end

   // Drives one block (pattern 0: zeros, 1: single one then zeros, 2: random) and
   // compares the complete K+3 output stream with the model.
   task automatic applyStimulus(input int k, input int gap_pct, input int pattern,
                                input bit inject);
      int i, n, lec0;
      blk_bits.delete();
      for (int b = 0; b < k; b++)
         blk_bits.push_back(pattern == 2 ? bit'($urandom_range(1)) :
                            (pattern == 1 && b == 0));
      buildExpected(k);
      lec0 = len_err_cnt;
      @(negedge clk);
      obs_q.delete();
      bus.blklen       = 16'(k);
      bus.valid_blklen = 1'b1;
      @(negedge clk);
      bus.valid_blklen = 1'b0;
      checkOutput("ready_start", bus.ready, 1);
      i = 0;
      while (i < k) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            bus.valid_in = 1'b0;
            bus.in_bit   = bit'($urandom_range(1));
         end else begin
            bus.valid_in = 1'b1;
            bus.in_bit   = blk_bits[i];
            i++;
         end
         @(negedge clk);
      end
      bus.valid_in = 1'b0;
      checkOutput("ready_drop", bus.ready, 0);
      if (inject) begin
         bus.blklen       = 16'd6144;
         bus.valid_blklen = 1'b1;
         @(negedge clk);
         bus.valid_blklen = 1'b0;
      end
      for (int w = 0; w < 20 && obs_q.size() < k + 3; w++) @(negedge clk);
      checkOutput("out_count", obs_q.size(), k + 3);
      checkOutput("no_len_err", len_err_cnt - lec0, 0);
      checkOutput("ready_idle", bus.ready, 0);
      n = (obs_q.size() < k + 3) ? obs_q.size() : k + 3;
      for (int j = 0; j < n; j++) begin
         checkOutput("sys", obs_q[j].sys, exp_q[j].sys);
         checkOutput("par", obs_q[j].par, exp_q[j].par);
         checkOutput("tail_out", obs_q[j].tl, exp_q[j].tl);
         checkOutput("last_out", obs_q[j].ls, exp_q[j].ls);
         if (j >= k) checkOutput("tail_gap", obs_q[j].cyc - obs_q[j-1].cyc, 1);
      end
   endtask

   task automatic lengthReject(input int len);
      int lec0;
      lec0 = len_err_cnt;
      @(negedge clk);
      obs_q.delete();
      bus.blklen       = 16'(len);
      bus.valid_blklen = 1'b1;
      @(negedge clk);
      bus.valid_blklen = 1'b0;
      checkOutput("len_err_hi", bus.len_err, 1);
      checkOutput("ready_rej", bus.ready, 0);
      @(negedge clk);
      checkOutput("len_err_lo", bus.len_err, 0);
      repeat (3) @(negedge clk);
      checkOutput("len_err_cnt", len_err_cnt - lec0, 1);
      checkOutput("no_out_rej", obs_q.size(), 0);
   endtask

   initial begin
      errors           = 0;
      checks           = 0;
      cyc              = 0;
      len_err_cnt      = 0;
      rst              = 1'b1;
      bus.blklen       = '0;
      bus.valid_blklen = 1'b0;
      bus.in_bit       = 1'b0;
      bus.valid_in     = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", bus.ready, 0);
      checkOutput("rst_valid", bus.valid_out, 0);
      checkOutput("rst_tail", bus.tail_out, 0);
      checkOutput("rst_last", bus.last_out, 0);
      checkOutput("rst_lenerr", bus.len_err, 0);
      checkOutput("rst_sys", bus.sys, 0);
      checkOutput("rst_par", bus.par, 0);
      rst = 1'b0;

      applyStimulus(40, 0, 0, 1'b0);
      applyStimulus(40, 20, 1, 1'b0);
      applyStimulus(6144, 25, 2, 1'b0);
      lengthReject(39);
      lengthReject(6145);

      // Abort a K=512 block after 100 bits with a synchronous reset.
      @(negedge clk);
      bus.blklen       = 16'd512;
      bus.valid_blklen = 1'b1;
      @(negedge clk);
      bus.valid_blklen = 1'b0;
      for (int b = 0; b < 100; b++) begin
         bus.valid_in = 1'b1;
         bus.in_bit   = bit'($urandom_range(1));
         @(negedge clk);
      end
      bus.valid_in = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid_rst_ready", bus.ready, 0);
      checkOutput("mid_rst_valid", bus.valid_out, 0);
      checkOutput("mid_rst_sys", bus.sys, 0);
      checkOutput("mid_rst_par", bus.par, 0);
      obs_q.delete();
      repeat (5) @(negedge clk);
      checkOutput("mid_rst_quiet", obs_q.size(), 0);
      applyStimulus(40, 10, 2, 1'b0);

      // Strobe during TAIL must be ignored; the next block then follows back-to-back.
      applyStimulus(512, 15, 2, 1'b1);
      applyStimulus(40, 0, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
